// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared defaults, state encoding and command/response types for the APB master bridge
package apb_pkg;
  localparam int APB_DATA_WIDTH = 8;
  localparam int APB_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait-state counter with timeout flag
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flags the wait cycle whose closing edge must abort the transfer.
  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat command port to APB SETUP/ACCESS initiator
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);
  apb_state_e state;
  logic       accept;
  logic       timer_expired;

  // Held low during reset so the port only opens once PRESET is released.
  assign cmd_ready = !PRESET && ((state == IDLE) || ((state == ACCESS) && PREADY));
  assign accept    = cmd_valid && cmd_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clr    (state != ACCESS),
    .en     ((state == ACCESS) && !PREADY),
    .expired(timer_expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          PENABLE <= 1'b0;
          if (accept) begin
            PSELx  <= 1'b1;
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            state  <= SETUP;
          end else begin
            PSELx <= 1'b0;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            PENABLE   <= 1'b0;
            // A command accepted on the completing edge skips IDLE entirely.
            if (accept) begin
              PADDR  <= cmd_addr;
              PWRITE <= cmd_write;
              PWDATA <= cmd_wdata;
              state  <= SETUP;
            end else begin
              PSELx <= 1'b0;
              state <= IDLE;
            end
          end else if (timer_expired) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a wait-state APB slave model
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       PSELx;
  logic       PENABLE;
  logic [7:0] PADDR;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       PREADY = 1'b0;
  logic [7:0] PRDATA = '0;
  logic       PSLVERR = 1'b0;

  typedef struct {
    apb_cmd_t cmd;
    apb_rsp_t rsp;
    int       lat;
    int       acc;
  } exp_t;

  typedef struct {
    int         waits;
    logic [7:0] rdata;
    logic       err;
  } slv_t;

  exp_t sbq[$];
  exp_t apbq[$];
  slv_t slq[$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int last_rsp_cyc = 0;
  int prev_rsp_cyc = 0;

  apb_master_bridge #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave: wait states are counted from the SETUP cycle; noise is driven whenever PREADY is low.
  initial begin
    slv_t cur;
    int   cnt;
    cnt = 0;
    cur = '{waits: 0, rdata: 8'h00, err: 1'b0};
    forever begin
      @(posedge PCLK);
      #2;
      if (PSELx && !PENABLE) begin
        if (slq.size() > 0) cur = slq.pop_front();
        cnt     = cur.waits;
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end else if (PSELx && PENABLE && cnt > 0) begin
        cnt--;
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end else if (PSELx && PENABLE) begin
        PREADY  = 1'b1;
        PSLVERR = cur.err;
        PRDATA  = cur.rdata;
      end else begin
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end
    end
  end

  // Monitor: APB address phase against the active command, responses against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge PCLK);
    if (!PRESET) begin
      if (PSELx && apbq.size() > 0) begin
        check("paddr", 32'(PADDR), 32'(apbq[0].cmd.addr));
        check("pwrite", 32'(PWRITE), 32'(apbq[0].cmd.write));
        check("pwdata", 32'(PWDATA), 32'(apbq[0].cmd.wdata));
        if (PENABLE && PREADY) void'(apbq.pop_front());
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rsp.rdata));
          check("rsp_err", 32'(rsp_err), 32'(e.rsp.err));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.rsp.timeout));
          check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          if (e.rsp.timeout) begin
            check("psel_after_timeout", 32'({PSELx, PENABLE}), 32'd0);
            if (apbq.size() > 0) void'(apbq.pop_front());
          end
          prev_rsp_cyc = last_rsp_cyc;
          last_rsp_cyc = cyc;
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge with cmd_valid still high.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int waits, input logic [7:0] rd, input logic se);
    exp_t e;
    slv_t s;
    bit   got;
    got       = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        e.cmd = '{write: w, addr: a, wdata: d};
        if (waits >= TO) begin
          e.rsp = '{rdata: 8'h00, err: 1'b1, timeout: 1'b1};
          e.lat = TO + 2;
        end else begin
          e.rsp = '{rdata: (w ? 8'h00 : rd), err: se, timeout: 1'b0};
          e.lat = 3 + waits;
        end
        e.acc = cyc;
        s     = '{waits: waits, rdata: rd, err: se};
        sbq.push_back(e);
        apbq.push_back(e);
        slq.push_back(s);
        got = 1'b1;
      end
    end
    check("cmd_accept", 32'(got), 32'd1);
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge PCLK);
    check("drain", 32'(sbq.size()), 32'd0);
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_outputs", 32'({PSELx, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid,
                                rsp_rdata, rsp_err, rsp_timeout, cmd_ready}), 32'd0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;

    // Zero-wait write
    send(1'b1, 8'h10, 8'h3C, 0, 8'h00, 1'b0);
    check("setup_phase", 32'({PSELx, PENABLE}), 32'b10);
    idle_cmd();
    @(posedge PCLK);
    #1;
    check("access_phase", 32'({PSELx, PENABLE}), 32'b11);
    drain();

    // Read with three wait states: PREADY lands in the final timeout cycle, completion wins
    send(1'b0, 8'h22, 8'h77, 3, 8'hA5, 1'b0);
    idle_cmd();
    drain();

    // Back-to-back write then read, no IDLE gap
    send(1'b1, 8'h04, 8'h01, 0, 8'h00, 1'b0);
    send(1'b0, 8'h05, 8'h00, 0, 8'h5A, 1'b0);
    idle_cmd();
    drain();
    check("b2b_rsp_gap", 32'(last_rsp_cyc - prev_rsp_cyc), 32'd2);

    // Slave error on read
    send(1'b0, 8'h30, 8'h00, 0, 8'hC3, 1'b1);
    idle_cmd();
    drain();

    // Stuck slave: timeout, then a normal command
    send(1'b0, 8'h40, 8'h00, 100, 8'h00, 1'b0);
    idle_cmd();
    drain();
    send(1'b1, 8'h41, 8'h99, 1, 8'h00, 1'b0);
    idle_cmd();
    drain();

    // Random mix, some back-to-back
    for (int k = 0; k < 8; k++) begin
      send(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
           8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cmd();
    end
    idle_cmd();
    drain();

    // Reset during the second ACCESS wait cycle
    send(1'b0, 8'h33, 8'h00, 100, 8'h00, 1'b0);
    idle_cmd();
    @(posedge PCLK);
    #1;
    check("rst_first_access", 32'({PSELx, PENABLE}), 32'b11);
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    sbq.delete();
    apbq.delete();
    slq.delete();
    @(posedge PCLK);
    #1;
    @(negedge PCLK);
    check("mid_reset_outputs", 32'({PSELx, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid,
                                    rsp_rdata, rsp_err, rsp_timeout, cmd_ready}), 32'd0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
    check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    @(posedge PCLK);
    #1;
    send(1'b0, 8'h50, 8'h00, 0, 8'h3E, 1'b0);
    idle_cmd();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
